// File: rtl/soc_timer_pkg.sv
// soc_timer_pkg: shared definitions for the machine timer peripheral.
//   - Byte offsets of the timer registers on the data bus.
//   - CTRL register bit positions.
//   - Reset value of mtimecmp.
//   - Byte-lane helpers for partial bus writes.
package soc_timer_pkg;

    localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
    localparam logic [4:0] CTRL_OFS        = 5'h10;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_DIV_LSB = 8;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

    // Replace only the enabled bytes of old_word with new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] m;
        m = sel_mask(sel);
        return (old_word & ~m) | (new_word & m);
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides clk down to the mtime tick rate.
//   clk     in   system clock
//   reset_n in   synchronous active-low reset
//   en      in   count enable; count holds while low
//   div     in   divisor; one tick every div+1 enabled cycles
//   clr     in   force the count back to 0 (has priority over counting)
//   tick    out  one-cycle pulse, combinational from the current count
module mtimer_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_q;

    assign tick = en && (count_q == div);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// mtimer: CLINT-style machine timer on a Wishbone-like data bus.
//   clk, reset_n          clock and synchronous active-low reset
//   wb_cyc_i, wb_stb_i    request qualifiers
//   wb_we_i               1 = write, 0 = read
//   wb_adr_i[4:0]         byte address, [4:2] selects the register
//   wb_dat_i, wb_sel_i    write data and byte enables
//   wb_dat_o, wb_ack_o    registered read data and single-cycle acknowledge
//   timer_irq             registered level: mtime >= mtimecmp
module mtimer
    import soc_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8,
    parameter bit          EN_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        timer_irq
);

    localparam logic [2:0]  IDX_MTIME_LO    = MTIME_LO_OFS[4:2];
    localparam logic [2:0]  IDX_MTIME_HI    = MTIME_HI_OFS[4:2];
    localparam logic [2:0]  IDX_MTIMECMP_LO = MTIMECMP_LO_OFS[4:2];
    localparam logic [2:0]  IDX_MTIMECMP_HI = MTIMECMP_HI_OFS[4:2];
    localparam logic [2:0]  IDX_CTRL        = CTRL_OFS[4:2];
    localparam logic [31:0] DIV_MASK = ((32'd1 << PRESCALE_W) - 32'd1) << CTRL_DIV_LSB;

    logic [63:0]           mtime_q;
    logic [63:0]           mtimecmp_q;
    logic                  en_q;
    logic [PRESCALE_W-1:0] div_q;
    logic [31:0]           hi_shadow_q;

    logic        req;
    logic        rd;
    logic        wr;
    logic [2:0]  reg_idx;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_new;
    logic [31:0] rdata;
    logic        tick;
    logic        presc_clr;
    logic        unused_bits;

    // A request is accepted only when no ack is currently out, giving one ack per strobe.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd      = req & ~wb_we_i;
    // A write with no byte enables is acked but must not block the tick increment.
    assign wr      = req & wb_we_i & (|wb_sel_i);
    assign reg_idx = wb_adr_i[4:2];

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT] = en_q;
        ctrl_word[CTRL_DIV_LSB +: PRESCALE_W] = div_q;
    end

    assign ctrl_new    = merge_bytes(ctrl_word, wb_dat_i, wb_sel_i);
    assign unused_bits = ^{wb_adr_i[1:0], ctrl_new};

    // Count restarts when DIV bytes are written or when EN falls.
    assign presc_clr = wr && (reg_idx == IDX_CTRL) &&
                       ((|(sel_mask(wb_sel_i) & DIV_MASK)) ||
                        (en_q && !ctrl_new[CTRL_EN_BIT]));

    always_comb begin
        rdata = '0;
        case (reg_idx)
            IDX_MTIME_LO:    rdata = mtime_q[31:0];
            IDX_MTIME_HI:    rdata = hi_shadow_q;
            IDX_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            IDX_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            IDX_CTRL:        rdata = ctrl_word;
            default:         rdata = '0;
        endcase
    end

    mtimer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en_q),
        .div    (div_q),
        .clr    (presc_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RESET;
            en_q        <= EN_RESET;
            div_q       <= '0;
            hi_shadow_q <= '0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            timer_irq   <= 1'b0;
        end else begin
            wb_ack_o  <= req;
            wb_dat_o  <= rd ? rdata : 32'd0;
            timer_irq <= (mtime_q >= mtimecmp_q);

            if (rd && (reg_idx == IDX_MTIME_LO)) begin
                hi_shadow_q <= mtime_q[63:32];
            end

            // A bus write to either mtime half replaces that edge's increment.
            if (wr && (reg_idx == IDX_MTIME_LO)) begin
                mtime_q[31:0] <= merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i);
            end else if (wr && (reg_idx == IDX_MTIME_HI)) begin
                mtime_q[63:32] <= merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end

            if (wr && (reg_idx == IDX_MTIMECMP_LO)) begin
                mtimecmp_q[31:0] <= merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
            end
            if (wr && (reg_idx == IDX_MTIMECMP_HI)) begin
                mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
            end

            if (wr && (reg_idx == IDX_CTRL)) begin
                en_q  <= ctrl_new[CTRL_EN_BIT];
                div_q <= ctrl_new[CTRL_DIV_LSB +: PRESCALE_W];
            end
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: randomized and directed bench for mtimer with a cycle-level reference model.
module tb_mtimer;

    localparam logic [4:0] A_LO    = 5'h00;
    localparam logic [4:0] A_HI    = 5'h04;
    localparam logic [4:0] A_CMPLO = 5'h08;
    localparam logic [4:0] A_CMPHI = 5'h0C;
    localparam logic [4:0] A_CTRL  = 5'h10;

    logic        clk;
    logic        reset_n;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        timer_irq;

    int checks;
    int failures;
    bit chk_on;

    mtimer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the whole peripheral state as plain values, advanced once per clock.
    typedef struct packed {
        logic [63:0] mtime;
        logic [63:0] cmp;
        logic        en;
        logic [7:0]  div;
        logic [7:0]  cnt;
        logic [31:0] shadow;
        logic        ack;
        logic [31:0] dat;
        logic        irq;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_step(input mstate_t s, input logic rst_n, input logic cyc,
                                           input logic stb, input logic we,
                                           input logic [4:0] adr, input logic [31:0] d,
                                           input logic [3:0] sel);
        mstate_t     n;
        logic        req;
        logic        tick;
        logic [31:0] m;
        logic [31:0] ctrl;
        logic [31:0] cw;
        logic [31:0] rv;
        n = '0;
        if (!rst_n) begin
            n.cmp = '1;
            n.en  = 1'b1;
            return n;
        end
        n    = s;
        req  = cyc && stb && !s.ack;
        tick = s.en && (s.cnt == s.div);
        if (s.en) n.cnt = tick ? 8'd0 : s.cnt + 8'd1;
        if (tick) n.mtime = s.mtime + 64'd1;
        n.irq = (s.mtime >= s.cmp);
        n.ack = req;
        n.dat = '0;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
        ctrl = {16'd0, s.div, 7'd0, s.en};
        rv   = '0;
        if (req && !we) begin
            case (adr[4:2])
                3'd0: rv = s.mtime[31:0];
                3'd1: rv = s.shadow;
                3'd2: rv = s.cmp[31:0];
                3'd3: rv = s.cmp[63:32];
                3'd4: rv = ctrl;
                default: rv = '0;
            endcase
            n.dat = rv;
            if (adr[4:2] == 3'd0) n.shadow = s.mtime[63:32];
        end else if (req && we && (sel != 4'd0)) begin
            case (adr[4:2])
                3'd0: n.mtime = {s.mtime[63:32], (s.mtime[31:0] & ~m) | (d & m)};
                3'd1: n.mtime = {(s.mtime[63:32] & ~m) | (d & m), s.mtime[31:0]};
                3'd2: n.cmp = {s.cmp[63:32], (s.cmp[31:0] & ~m) | (d & m)};
                3'd3: n.cmp = {(s.cmp[63:32] & ~m) | (d & m), s.cmp[31:0]};
                3'd4: begin
                    cw    = (ctrl & ~m) | (d & m);
                    n.en  = cw[0];
                    n.div = cw[15:8];
                    if (sel[1] || (s.en && !cw[0])) n.cnt = 8'd0;
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ms <= model_step(ms, reset_n, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i);
    end

    // Every cycle: outputs must match the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", {63'd0, wb_ack_o}, {63'd0, ms.ack});
            check("irq", {63'd0, timer_irq}, {63'd0, ms.irq});
            check("rdata", {32'd0, wb_dat_o}, {32'd0, ms.dat});
        end
    end

    // Called on a negedge; returns on the negedge after the ack edge.
    task automatic bus_xfer(input logic we, input logic [4:0] adr, input logic [31:0] d,
                            input logic [3:0] sel, output logic [31:0] rdv);
        bit got;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = d;
        wb_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (wb_ack_o) got = 1'b1;
        end
        rdv = wb_dat_o;
        check("ack_seen", {63'd0, got}, 64'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] d, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        bus_xfer(1'b1, adr, d, sel, dummy);
    endtask

    task automatic rd(input logic [4:0] adr, output logic [31:0] v);
        bus_xfer(1'b0, adr, 32'd0, 4'hF, v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        bit          seen;
        logic [4:0]  ra;
        logic [31:0] rdat;
        checks   = 0;
        failures = 0;
        chk_on   = 1'b0;
        reset_n  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {63'd0, wb_ack_o}, 64'd0);
        check("rst_irq", {63'd0, timer_irq}, 64'd0);
        check("rst_dat", {32'd0, wb_dat_o}, 64'd0);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // Free run at DIV=0: ten ticks before the capturing edge.
        idle(10);
        rd(A_LO, v);
        check("idle_lo", {32'd0, v}, 64'd10);

        // DIV=3: any 40 consecutive edges hold exactly 10 ticks.
        wr(A_CTRL, 32'h0000_0301);
        rd(A_LO, a);
        idle(39);
        rd(A_LO, b);
        check("div3_diff", {32'd0, b - a}, 64'd10);
        rd(A_CTRL, v);
        check("ctrl_read", {32'd0, v}, 64'h301);

        // 64-bit wrap.
        wr(A_CTRL, 32'h1);
        wr(A_HI, 32'h0);
        wr(A_LO, 32'hFFFF_FFFE);
        wr(A_HI, 32'hFFFF_FFFF);
        idle(3);
        rd(A_LO, v);
        check("wrap_lo_small", {63'd0, v < 32'd8}, 64'd1);
        rd(A_HI, v);
        check("wrap_hi", {32'd0, v}, 64'd0);

        // HI read returns the shadow taken at the LO read, not the live value.
        wr(A_HI, 32'h5);
        wr(A_LO, 32'hFFFF_FFF0);
        rd(A_LO, v);
        idle(30);
        rd(A_HI, v);
        check("shadow_hi", {32'd0, v}, 64'd5);
        rd(A_LO, v);
        rd(A_HI, v);
        check("shadow_hi_new", {32'd0, v}, 64'd6);

        // Compare interrupt rise and fall.
        wr(A_HI, 32'h0);
        wr(A_LO, 32'h0);
        wr(A_CMPHI, 32'h0);
        wr(A_CMPLO, 32'd50);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (timer_irq) seen = 1'b1;
        end
        check("irq_rise_seen", {63'd0, seen}, 64'd1);
        wr(A_CMPLO, 32'hFFFF_FFFF);
        check("irq_at_ack", {63'd0, timer_irq}, 64'd1);
        @(negedge clk);
        check("irq_fall", {63'd0, timer_irq}, 64'd0);

        // Write on a tick edge: no lost or doubled increment.
        wr(A_LO, 32'h100);
        idle(5);
        rd(A_LO, v);
        check("tickwr_lo", {32'd0, v}, 64'h105);

        // Byte enables, with the counter stopped.
        wr(A_CTRL, 32'h0);
        wr(A_LO, 32'h1234_5678);
        wr(A_LO, 32'h0000_00AB, 4'b0001);
        rd(A_LO, v);
        check("sel_byte0", {32'd0, v}, 64'h1234_56AB);
        wr(A_LO, 32'hFFFF_FFFF, 4'b0000);
        idle(5);
        rd(A_LO, v);
        check("sel_none_hold", {32'd0, v}, 64'h1234_56AB);
        rd(5'h18, v);
        check("unmapped_read", {32'd0, v}, 64'd0);
        wr(A_CTRL, 32'h1);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            ra   = {$urandom_range(0, 7), 2'($urandom)};
            rdat = $urandom;
            if ((ra[4:2] == 3'd1 || ra[4:2] == 3'd3) && $urandom_range(0, 3) != 0) rdat = 32'd0;
            if (ra[4:2] == 3'd2 && $urandom_range(0, 1) != 0) rdat = {24'd0, rdat[7:0]};
            if (ra[4:2] == 3'd4) begin
                rdat = {16'd0, 6'd0, 2'($urandom), 7'd0, ($urandom_range(0, 3) != 0)};
            end
            if ($urandom_range(0, 1) != 0) begin
                wr(ra, rdat, 4'($urandom));
            end else begin
                rd(ra, v);
            end
            idle($urandom_range(0, 3));
        end

        // Reset with a strobe pending and the interrupt high.
        wr(A_CTRL, 32'h1);
        wr(A_CMPHI, 32'h0);
        wr(A_CMPLO, 32'h0);
        idle(2);
        check("irq_pre_rst", {63'd0, timer_irq}, 64'd1);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = A_CTRL;
        wb_dat_i = 32'h0000_0500;
        wb_sel_i = 4'hF;
        reset_n  = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", {63'd0, wb_ack_o}, 64'd0);
        check("rst_mid_irq", {63'd0, timer_irq}, 64'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        reset_n  = 1'b1;
        rd(A_CMPLO, v);
        check("rst_cmplo", {32'd0, v}, 64'hFFFF_FFFF);
        rd(A_CMPHI, v);
        check("rst_cmphi", {32'd0, v}, 64'hFFFF_FFFF);
        rd(A_CTRL, v);
        check("rst_ctrl", {32'd0, v}, 64'h1);
        rd(A_HI, v);
        check("rst_shadow", {32'd0, v}, 64'd0);
        rd(A_LO, v);
        check("rst_mtime_small", {63'd0, v < 32'd16}, 64'd1);
        idle(2);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Machine timer peripheral, CLINT-style, on the SoC data bus.
- Holds a 64-bit free-running mtime counter with a programmable prescaler, plus a 64-bit mtimecmp compare register.
- Drives the registered timer_irq level consumed directly by the core's CSR file (mip.MTIP).
- Software reloads mtimecmp to acknowledge or re-arm the interrupt.

Parameters:
- PRESCALE_W, 8: width of the CTRL.DIV field and the prescaler counter.
- EN_RESET, 1: reset value of CTRL.EN (1 = counter runs out of reset).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe for this slave
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  5  byte address; bits [4:2] select the register, bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_dat_o  out  32  read data, valid while wb_ack_o = 1
- wb_ack_o  out  1  transfer acknowledge
- timer_irq  out  1  level interrupt to the CSR file

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; CTRL.EN = EN_RESET; CTRL.DIV = 0.
  - Prescaler count = 0; hi shadow = 0.
  - wb_ack_o = 0, wb_dat_o = 0, timer_irq = 0.
  - A reset mid-transfer drops ack in the next cycle; the transfer is lost and no register is written.
- Register map (word offset): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits [8+PRESCALE_W-1:8] DIV, all other bits read 0).
  - Offsets 0x14–0x1C read 0; writes to them are ignored but still acked.
- Handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o, giving exactly one ack per request, one cycle after strobe.
  - A held strobe yields ack on alternate cycles.
  - The write takes effect at the same edge that raises ack.
  - wb_dat_o is registered at that edge and returns 0 when no ack is being raised.
- Byte enables: each wb_sel_i[n] gates byte n of the write. A write with sel = 0 is acked and has no effect.
- Prescaler:
  - While EN = 1, the count increments each cycle.
  - When count == DIV, a tick occurs and the count returns to 0, so the mtime rate is clk/(DIV+1). DIV = 0 ticks every cycle.
  - While EN = 0, the count holds, and it is cleared at the edge EN goes 0.
  - Writing DIV clears the count.
- mtime:
  - Increments by 1 on each tick and wraps from 2^64−1 to 0.
  - A bus write to either half at the same edge as a tick wins: the written half takes the new data, the other half holds, and there is no increment that edge.
- Coherent read: a read of MTIME_LO captures mtime[63:32] into the hi shadow at the same edge. A read of MTIME_HI returns the shadow, not the live value.
- timer_irq:
  - Registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - It rises one cycle after the condition becomes true and falls one cycle after an mtimecmp/mtime write makes it false.
  - It is independent of EN.
  - No latching: the level follows the compare.

Decomposition:
- Shared package soc_timer_pkg:
  - register offset localparams (MTIME_LO_OFS … CTRL_OFS);
  - CTRL bit positions;
  - MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF.
- One natural sub-module, mtimer_prescaler:
  - inputs: clk, reset_n, en, div, clr;
  - output: tick.
- Register file, bus logic and compare stay in mtimer.

Test Plan:
- Reset then idle 10 cycles with DIV = 0, EN = 1 -> read MTIME_LO returns 10 ± handshake offset (exact value checked against the model); timer_irq stays 0.
- Write CTRL DIV = 3, then read MTIME_LO twice 40 cycles apart -> difference = 10.
- Write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, MTIME_HI = 0xFFFF_FFFF; DIV = 0 -> mtime wraps to 0 within 2 ticks; MTIME_LO read then MTIME_HI read returns the shadow captured at the LO read.
- Write MTIMECMP_HI = 0, MTIMECMP_LO = 50 with mtime = 0 -> timer_irq rises exactly one cycle after mtime reaches 50. Then write MTIMECMP_LO = 0xFFFF_FFFF -> timer_irq falls one cycle after the write ack.
- Write MTIME_LO = 0x100 on a tick edge -> next read returns 0x100 + elapsed ticks after the write, with no lost or doubled increment; a write with wb_sel_i = 4'b0001, data 0xAB, updates byte 0 only.
- Assert reset_n = 0 with a strobe pending and timer_irq high -> next cycle wb_ack_o = 0, timer_irq = 0, mtime = 0, mtimecmp = all ones.
